// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-PC pipeline.
//   DefaultWidth       : default PC width
//   DefaultResetVector : fetch PC after reset
//   DefaultInc         : sequential fetch increment
//   pc_stage_t         : one tracked stage, {valid, pc}
package pc_pkg;

  localparam int unsigned DefaultWidth       = 32;
  localparam logic [31:0] DefaultResetVector = 32'h0000_0060;
  localparam int unsigned DefaultInc         = 4;

  typedef struct packed {
    logic                    valid;
    logic [DefaultWidth-1:0] pc;
  } pc_stage_t;

endpackage

// File: rtl/pc_stage_reg.sv
// Single pipeline stage register holding a valid bit and a PC.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   hold             : keep current contents (takes priority over load)
//   clear            : load the PC but force valid low (squash)
//   in_valid, in_pc  : value to load
//   out_valid, out_pc: current contents
module pc_stage_reg
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (!hold) begin
      // A squash still shifts the PC; only the valid bit is dropped.
      valid_d = in_valid & ~clear;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/pc_pipeline.sv
// Fetch PC generator with DEPTH tracked downstream stages.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : hold fetch PC and all stages
//   redirect        : load redirect_target (word aligned) and squash stages
//   redirect_target : new fetch PC
//   pc_out          : current fetch PC
//   stage_pc        : flattened DEPTH x WIDTH, stage i at [i*WIDTH +: WIDTH], 0 youngest
//   stage_valid     : valid bit per stage
//   retire_valid    : oldest stage leaves the pipeline on this edge
//   retire_pc       : PC of the oldest stage
//   misalign        : one-cycle pulse after a redirect with target[1:0] != 0
module pc_pipeline
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DefaultResetVector),
  parameter int unsigned      DEPTH        = 3,
  parameter int unsigned      INC          = DefaultInc
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_target,
  output logic [WIDTH-1:0]       pc_out,
  output logic [DEPTH*WIDTH-1:0] stage_pc,
  output logic [DEPTH-1:0]       stage_valid,
  output logic                   retire_valid,
  output logic [WIDTH-1:0]       retire_pc,
  output logic                   misalign
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic             hold;

  logic [DEPTH-1:0] st_valid;
  logic [WIDTH-1:0] st_pc [DEPTH];

  // Redirect wins over stall, so a stall only freezes state when no redirect is present.
  assign hold = stall & ~redirect;

  always_comb begin
    pc_d       = pc_q + WIDTH'(INC);
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = {redirect_target[WIDTH-1:2], 2'b00};
      misalign_d = |redirect_target[1:0];
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             in_valid;
    logic [WIDTH-1:0] in_pc;

    if (i == 0) begin : g_head
      assign in_valid = 1'b1;
      assign in_pc    = pc_q;
    end else begin : g_body
      assign in_valid = st_valid[i-1];
      assign in_pc    = st_pc[i-1];
    end

    pc_stage_reg #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .clear    (redirect),
      .in_valid (in_valid),
      .in_pc    (in_pc),
      .out_valid(st_valid[i]),
      .out_pc   (st_pc[i])
    );

    assign stage_pc[i*WIDTH +: WIDTH] = st_pc[i];
  end

  assign pc_out       = pc_q;
  assign stage_valid  = st_valid;
  assign retire_valid = st_valid[DEPTH-1] & ~stall & ~redirect;
  assign retire_pc    = st_pc[DEPTH-1];
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_pc_pipeline.sv
module tb_pc_pipeline;
  import pc_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned D = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           stall = 1'b0;
  logic           redirect = 1'b0;
  logic [W-1:0]   redirect_target = '0;
  logic [W-1:0]   pc_out;
  logic [D*W-1:0] stage_pc;
  logic [D-1:0]   stage_valid;
  logic           retire_valid;
  logic [W-1:0]   retire_pc;
  logic           misalign;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pc_pipeline dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pc_out         (pc_out),
    .stage_pc       (stage_pc),
    .stage_valid    (stage_valid),
    .retire_valid   (retire_valid),
    .retire_pc      (retire_pc),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fetch PC plus a queue of in-flight entries, youngest at the front.
  logic [W-1:0] m_pc;
  logic         m_mis;
  pc_stage_t    m_q[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pc  = 32'h60;
      m_mis = 1'b0;
      m_q   = {};
      for (int i = 0; i < D; i++) m_q.push_back('{valid: 1'b0, pc: '0});
    end else if (redirect) begin
      void'(m_q.pop_back());
      m_q.push_front('{valid: 1'b0, pc: m_pc});
      foreach (m_q[i]) m_q[i].valid = 1'b0;
      m_pc  = redirect_target & ~32'h3;
      m_mis = redirect_target[1:0] != 2'b00;
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      void'(m_q.pop_back());
      m_q.push_front('{valid: 1'b1, pc: m_pc});
      m_pc  = m_pc + 32'd4;
      m_mis = 1'b0;
    end
  end

  // Mid-cycle comparison: registered state is settled and inputs are those for the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [D-1:0] ev;
      for (int i = 0; i < D; i++) ev[i] = m_q[i].valid;
      check("pc_out", 64'(pc_out), 64'(m_pc));
      check("stage_valid", 64'(stage_valid), 64'(ev));
      for (int i = 0; i < D; i++)
        check($sformatf("stage_pc[%0d]", i), 64'(stage_pc[i*W +: W]), 64'(m_q[i].pc));
      check("misalign", 64'(misalign), 64'(m_mis));
      check("retire_valid", 64'(retire_valid), 64'(m_q[D-1].valid & ~stall & ~redirect));
      check("retire_pc", 64'(retire_pc), 64'(m_q[D-1].pc));
    end
  end

  task automatic drive(input logic s, input logic r, input logic [W-1:0] t);
    stall           = s;
    redirect        = r;
    redirect_target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst pc_out", 64'(pc_out), 64'h60);
    check("rst stage_valid", 64'(stage_valid), 64'h0);
    check("rst stage_pc", 64'(stage_pc), 64'h0);
    check("rst misalign", 64'(misalign), 64'h0);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset release, free running.
    drive(1'b0, 1'b0, '0);
    tick();
    check("rel1 pc_out", 64'(pc_out), 64'h64);
    check("rel1 valid", 64'(stage_valid), 64'b001);
    tick();
    check("rel2 valid", 64'(stage_valid), 64'b011);
    tick();
    check("rel3 valid", 64'(stage_valid), 64'b111);
    check("rel3 retire_valid", 64'(retire_valid), 64'h1);
    check("rel3 retire_pc", 64'(retire_pc), 64'h60);

    // Stall at pc_out = 0x68.
    do_reset();
    tick();
    tick();
    check("pre-stall pc", 64'(pc_out), 64'h68);
    drive(1'b1, 1'b0, '0);
    #1 check("stall retire_valid", 64'(retire_valid), 64'h0);
    tick();
    tick();
    check("stall pc held", 64'(pc_out), 64'h68);
    check("stall valid held", 64'(stage_valid), 64'b011);
    drive(1'b0, 1'b0, '0);
    tick();
    check("resume pc", 64'(pc_out), 64'h6C);

    // Redirect together with stall.
    tick();
    drive(1'b1, 1'b1, 32'h200);
    #1 check("redir retire_valid", 64'(retire_valid), 64'h0);
    tick();
    check("redir pc", 64'(pc_out), 64'h200);
    check("redir valid", 64'(stage_valid), 64'b000);
    drive(1'b0, 1'b0, '0);
    tick();
    tick();
    tick();
    check("redir retire_pc", 64'(retire_pc), 64'h200);
    check("redir retire_valid2", 64'(retire_valid), 64'h1);

    // Misaligned target.
    drive(1'b0, 1'b1, 32'h203);
    tick();
    check("mis pc", 64'(pc_out), 64'h200);
    check("mis pulse", 64'(misalign), 64'h1);
    drive(1'b0, 1'b0, '0);
    tick();
    check("mis cleared", 64'(misalign), 64'h0);

    // Wrap past the top of the address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    check("wrap pc0", 64'(pc_out), 64'hFFFF_FFFC);
    drive(1'b0, 1'b0, '0);
    tick();
    check("wrap pc1", 64'(pc_out), 64'h0);

    // Mixed directed pattern, checked by the model each cycle.
    for (int i = 0; i < 16; i++) begin
      drive(i % 5 == 2, i % 7 == 3, 32'h1000 + 32'(i * 3));
      tick();
    end
    drive(1'b0, 1'b0, '0);
    tick();

    // Reset between edges during a redirect: the redirect is dropped.
    drive(1'b0, 1'b1, 32'h400);
    #2 rst = 1'b1;
    #1;
    check("arst pc", 64'(pc_out), 64'h60);
    check("arst valid", 64'(stage_valid), 64'h0);
    check("arst stage_pc", 64'(stage_pc), 64'h0);
    check("arst misalign", 64'(misalign), 64'h0);
    tick();
    drive(1'b0, 1'b0, '0);
    rst = 1'b0;
    tick();
    check("post-arst pc", 64'(pc_out), 64'h64);
    check("post-arst valid", 64'(stage_valid), 64'b001);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
